// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package riscv_pkg;

    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;
    localparam int LANE_W          = $clog2(BYTES_PER_INSTR);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        LOAD,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    function automatic logic is_receiving(input loader_state_t st);
        return (st == HDR_LO) || (st == HDR_HI) || (st == LOAD) || (st == CHK);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 32
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: byte source and memory side; slave: the loader itself
    modport master (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word_done marks the
// transfer of the last byte of a word, with the full word on 'word'.
module word_assembler
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic [INSTR_W-1:0] word,
    output logic               word_done
);

    logic [LANE_W-1:0]    lane;
    logic [INSTR_W-9:0]   shreg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            lane  <= lane + 1'b1;
            shreg <= {byte_data, shreg[INSTR_W-9:8]};
        end
    end

    // Earlier bytes have been shifted down, so the current byte lands on top.
    assign word      = {byte_data, shreg};
    assign word_done = byte_valid && (lane == LANE_W'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length header + program image byte stream into instruction
// memory, then releases the core. Optional trailing checksum: IMEM_BOOT_CHECKSUM_EN.
//
// state  | meaning
// HDR_LO | waiting for word count bits [7:0]
// HDR_HI | waiting for word count bits [15:8]
// LOAD   | receiving payload bytes, one memory write per 4 bytes
// CHK    | waiting for XOR checksum byte (checksum build only)
// DONE   | image complete, core_run high
// ERR    | load rejected, error high
module imem_boot_loader
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                core_run,
    output logic                busy,
    output logic                error,
    output logic [15:0]         words_loaded
);

    localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam loader_state_t FINISH_ST = CHK;
`else
    localparam loader_state_t FINISH_ST = DONE;
`endif

    loader_state_t      state, state_next;
    logic               take;
    logic [7:0]         hdr_lo;
    logic [15:0]        hdr_n;
    logic [15:0]        n_words;
    logic               last_word;
    logic [INSTR_W-1:0] asm_word;
    logic               word_done;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]         cks_acc;
`endif

    assign take      = bus.s_valid && bus.s_ready;
    assign hdr_n     = {bus.s_data, hdr_lo};
    assign last_word = (words_loaded + 16'd1) == n_words;

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (take && (state == LOAD)),
        .byte_data  (bus.s_data),
        .word       (asm_word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= HDR_LO;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        core_run   = 1'b0;
        error      = 1'b0;
        case (state)
            HDR_LO: if (take) state_next = HDR_HI;
            HDR_HI: begin
                busy = 1'b1;
                if (take) begin
                    if ({1'b0, hdr_n} > MAX_WORDS_C) state_next = ERR;
                    else if (hdr_n == 16'd0)         state_next = FINISH_ST;
                    else                             state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (word_done && last_word) state_next = FINISH_ST;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CHK: begin
                busy = 1'b1;
                if (take) state_next = (bus.s_data == cks_acc) ? DONE : ERR;
            end
`endif
            DONE:    core_run = 1'b1;
            ERR:     error    = 1'b1;
            default: state_next = ERR;
        endcase
    end

    // The write is registered so it lands the cycle after the 4th byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.s_ready    <= 1'b0;
            hdr_lo         <= '0;
            n_words        <= '0;
            words_loaded   <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= '0;
        end else begin
            bus.s_ready <= is_receiving(state_next);
            bus.imem_we <= word_done;
            if (take && (state == HDR_LO)) hdr_lo  <= bus.s_data;
            if (take && (state == HDR_HI)) n_words <= hdr_n;
            if (word_done) begin
                bus.imem_addr  <= BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
                bus.imem_wdata <= asm_word;
                words_loaded   <= words_loaded + 16'd1;
            end
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset)                         cks_acc <= '0;
        else if (take && (state == LOAD))   cks_acc <= cks_acc ^ bus.s_data;
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized/directed bench for imem_boot_loader against a queue-based image model.
module tb_imem_boot_loader;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          MAX_WORDS = 256;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_run, busy, error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .core_run     (core_run),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"},      32'(bus.s_ready),    32'd0);
        chk({tag, "_imem_we"},      32'(bus.imem_we),    32'd0);
        chk({tag, "_imem_addr"},    bus.imem_addr,       BASE_ADDR);
        chk({tag, "_imem_wdata"},   bus.imem_wdata,      32'd0);
        chk({tag, "_core_run"},     32'(core_run),       32'd0);
        chk({tag, "_busy"},         32'(busy),           32'd0);
        chk({tag, "_error"},        32'(error),          32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded),   32'd0);
    endtask

    task automatic do_reset(input string tag);
        bus.s_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs(tag);
        reset = 1'b1;
    endtask

    // Presents one byte after 'gap' idle cycles (gap<0: random 0..2) and
    // returns the cycle number observed just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        int  g;
        bit  rdy;
        bit  done;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        bus.s_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        done = 1'b0;
        acc_cyc = -1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL ready_timeout observed=s_ready_low expected=accept_within_50");
        end
    endtask

    task automatic run_image(input string tag, input logic [15:0] n, input logic [7:0] pay[$],
                             input int gap, input logic [7:0] cks_delta);
        int          c;
        int          fourth[$];
        logic [7:0]  x;
        bit          bad_hdr;
        bit          exp_err;
        int          exp_writes;
        logic [31:0] w;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        bad_hdr = (int'(n) > MAX_WORDS);
        send_byte(n[7:0], gap, c);
        send_byte(n[15:8], gap, c);
        if (bad_hdr) begin
            chk({tag, "_err_next_cycle"}, 32'(error), 32'd1);
        end else begin
            x = 8'h00;
            foreach (pay[i]) begin
                send_byte(pay[i], gap, c);
                x ^= pay[i];
                if (i % 4 == 3) fourth.push_back(c);
            end
            if (CKS_EN) send_byte(x ^ cks_delta, gap, c);
        end
        repeat (2) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom);
        repeat (3) begin @(posedge clk); #1; end
        bus.s_valid = 1'b0;
        @(posedge clk); #1;

        exp_err    = bad_hdr || (CKS_EN && (cks_delta != 8'h00));
        exp_writes = bad_hdr ? 0 : int'(n);
        chk({tag, "_n_writes"}, 32'(wr_addr_q.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
            w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE_ADDR + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], w);
            chk($sformatf("%s_lat%0d", tag, i), 32'(wr_cyc_q[i]), 32'(fourth[i]));
        end
        chk({tag, "_core_run"},     32'(core_run),     32'(!exp_err));
        chk({tag, "_error"},        32'(error),        32'(exp_err));
        chk({tag, "_busy"},         32'(busy),         32'd0);
        chk({tag, "_s_ready"},      32'(bus.s_ready),  32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_writes));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img[$];
        logic [7:0] rnd[$];
        logic [7:0] none[$];
        int         c;
        int         n;

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        img = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        run_image("img_b2b", 16'd2, img, 0, 8'h00);

        do_reset("rst2");
        run_image("img_gap3", 16'd2, img, 3, 8'h00);

        for (int k = 0; k < 3; k++) begin
            do_reset($sformatf("rst_rnd%0d", k));
            n = $urandom_range(1, 5);
            rnd.delete();
            for (int i = 0; i < 4 * n; i++) rnd.push_back(8'($urandom));
            run_image($sformatf("rnd%0d", k), 16'(n), rnd, -1, 8'h00);
        end

        do_reset("rst_big");
        run_image("hdr_257", 16'd257, none, 0, 8'h00);

        do_reset("rst_max");
        rnd.delete();
        for (int i = 0; i < 4 * MAX_WORDS; i++) rnd.push_back(8'($urandom));
        run_image("hdr_max", 16'(MAX_WORDS), rnd, 0, 8'h00);

        do_reset("rst_zero");
        run_image("hdr_zero", 16'd0, none, 0, 8'h00);
        do_reset("rst_zero_bad");
        run_image("hdr_zero_cks1", 16'd0, none, 0, 8'h01);

        do_reset("rst_abort");
        send_byte(8'h02, 0, c);
        send_byte(8'h00, 0, c);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0, c);
        chk("abort_busy_before", 32'(busy), 32'd1);
        do_reset("abort");
        rnd.delete();
        for (int i = 0; i < 4; i++) rnd.push_back(8'($urandom));
        run_image("reload", 16'd1, rnd, 1, 8'h00);

        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset("rst_cks_bad");
        run_image("cks_45", 16'd1, img, 0, 8'h01);
        do_reset("rst_cks_ok");
        run_image("cks_44", 16'd1, img, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
